// File: rtl/axi_lite_reg_tester_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_tester_if
// Brief    : AXI4-Lite bus bundle with master/slave views.
// Revision : 1.0
// ============================================================================
interface axi_lite_reg_tester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
    logic                    m_axi_awvalid;
    logic                    m_axi_awready;
    logic [DATA_WIDTH-1:0]   m_axi_wdata;
    logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
    logic                    m_axi_wvalid;
    logic                    m_axi_wready;
    logic [1:0]              m_axi_bresp;
    logic                    m_axi_bvalid;
    logic                    m_axi_bready;
    logic [ADDR_WIDTH-1:0]   m_axi_araddr;
    logic                    m_axi_arvalid;
    logic                    m_axi_arready;
    logic [DATA_WIDTH-1:0]   m_axi_rdata;
    logic [1:0]              m_axi_rresp;
    logic                    m_axi_rvalid;
    logic                    m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
               m_axi_bready, m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_awready, m_axi_wready, m_axi_bresp, m_axi_bvalid,
               m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axi_lite_reg_tester.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_reg_tester
// Brief    : Writes a seeded pattern to NUM_REGS AXI4-Lite registers, reads
//            it back and reports pass/fail, error count and first bad address.
// Revision : 1.0
// ============================================================================
module axi_lite_reg_tester #(
    parameter int                    NUM_REGS   = 4,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    TIMEOUT    = 1024
) (
    input  wire logic                  ACLK,
    input  wire logic                  ARESET,
    input  wire logic                  start,
    input  wire logic                  mode,
    input  wire logic [DATA_WIDTH-1:0] seed,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [15:0]                err_count,
    output logic [ADDR_WIDTH-1:0]      fail_addr,
    axi_lite_reg_tester_if.master      m_axi
);

    localparam logic [DATA_WIDTH-1:0] c_ONES     = {(DATA_WIDTH/8){8'h01}};
    localparam logic [ADDR_WIDTH-1:0] c_STRIDE   = ADDR_WIDTH'(DATA_WIDTH/8);
    localparam logic [8:0]            c_LAST     = 9'(NUM_REGS-1);
    localparam logic [31:0]           c_TMO_LAST = 32'(TIMEOUT-1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] r_seed;
    logic [DATA_WIDTH-1:0] r_data;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [8:0]            r_idx;
    logic [31:0]           r_tcnt;
    logic                  r_aw_done, r_w_done;
    logic                  r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
    logic                  r_busy, r_done, r_pass;
    logic [15:0]           r_err_cnt;
    logic [ADDR_WIDTH-1:0] r_fail_addr;

    logic w_aw_hs, w_w_hs, w_aw_ok, w_w_ok, w_tmo, w_last, w_rd_bad, w_err;

    assign w_aw_hs  = r_awvalid & m_axi.m_axi_awready;
    assign w_w_hs   = r_wvalid & m_axi.m_axi_wready;
    assign w_aw_ok  = r_aw_done | w_aw_hs;
    assign w_w_ok   = r_w_done | w_w_hs;
    assign w_tmo    = (r_tcnt == c_TMO_LAST);
    assign w_last   = (r_idx == c_LAST);
    assign w_rd_bad = (m_axi.m_axi_rresp != 2'b00) || (m_axi.m_axi_rdata != r_data);

    // A handshake completing in the timeout cycle wins over the abort.
    always_comb begin
        w_err = 1'b0;
        case (r_state)
            S_WADDR: w_err = w_tmo & ~(w_aw_ok & w_w_ok);
            S_WRESP: w_err = m_axi.m_axi_bvalid ? (m_axi.m_axi_bresp != 2'b00) : w_tmo;
            S_RADDR: w_err = w_tmo & ~m_axi.m_axi_arready;
            S_RDATA: w_err = m_axi.m_axi_rvalid ? w_rd_bad : w_tmo;
            default: w_err = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_seed      <= '0;
            r_data      <= '0;
            r_addr      <= '0;
            r_idx       <= '0;
            r_tcnt      <= '0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_cnt   <= '0;
            r_fail_addr <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy      <= 1'b1;
                        r_pass      <= 1'b0;
                        r_err_cnt   <= '0;
                        r_fail_addr <= '0;
                        r_mode      <= mode;
                        r_seed      <= seed;
                        r_data      <= seed;
                        r_addr      <= BASE_ADDR;
                        r_idx       <= '0;
                        r_tcnt      <= '0;
                        r_awvalid   <= 1'b1;
                        r_wvalid    <= 1'b1;
                        r_aw_done   <= 1'b0;
                        r_w_done    <= 1'b0;
                        r_state     <= S_WADDR;
                    end
                end
                S_WADDR: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_ok && w_w_ok) begin
                        r_bready <= 1'b1;
                        r_tcnt   <= '0;
                        r_state  <= S_WRESP;
                    end else if (w_tmo) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_state   <= S_FIN;
                    end else begin
                        r_tcnt <= r_tcnt + 32'd1;
                    end
                end
                S_WRESP: begin
                    if (m_axi.m_axi_bvalid) begin
                        r_bready <= 1'b0;
                        r_tcnt   <= '0;
                        if (!r_mode) begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RADDR;
                        end else if (w_last) begin
                            // Batch mode: rewind to register 0 for the read sweep.
                            r_idx     <= '0;
                            r_addr    <= BASE_ADDR;
                            r_data    <= r_seed;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RADDR;
                        end else begin
                            r_idx     <= r_idx + 9'd1;
                            r_addr    <= r_addr + c_STRIDE;
                            r_data    <= r_data + c_ONES;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_aw_done <= 1'b0;
                            r_w_done  <= 1'b0;
                            r_state   <= S_WADDR;
                        end
                    end else if (w_tmo) begin
                        r_bready <= 1'b0;
                        r_state  <= S_FIN;
                    end else begin
                        r_tcnt <= r_tcnt + 32'd1;
                    end
                end
                S_RADDR: begin
                    if (m_axi.m_axi_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_tcnt    <= '0;
                        r_state   <= S_RDATA;
                    end else if (w_tmo) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_FIN;
                    end else begin
                        r_tcnt <= r_tcnt + 32'd1;
                    end
                end
                S_RDATA: begin
                    if (m_axi.m_axi_rvalid) begin
                        r_rready <= 1'b0;
                        r_tcnt   <= '0;
                        if (w_last) begin
                            r_state <= S_FIN;
                        end else begin
                            r_idx  <= r_idx + 9'd1;
                            r_addr <= r_addr + c_STRIDE;
                            r_data <= r_data + c_ONES;
                            if (r_mode) begin
                                r_arvalid <= 1'b1;
                                r_state   <= S_RADDR;
                            end else begin
                                r_awvalid <= 1'b1;
                                r_wvalid  <= 1'b1;
                                r_aw_done <= 1'b0;
                                r_w_done  <= 1'b0;
                                r_state   <= S_WADDR;
                            end
                        end
                    end else if (w_tmo) begin
                        r_rready <= 1'b0;
                        r_state  <= S_FIN;
                    end else begin
                        r_tcnt <= r_tcnt + 32'd1;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_err_cnt == 16'd0);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_err) begin
                if (r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                if (r_err_cnt == 16'd0) begin
                    r_fail_addr <= r_addr;
                end
            end
        end
    end

    assign m_axi.m_axi_awaddr  = r_addr;
    assign m_axi.m_axi_awvalid = r_awvalid;
    assign m_axi.m_axi_wdata   = r_data;
    assign m_axi.m_axi_wstrb   = '1;
    assign m_axi.m_axi_wvalid  = r_wvalid;
    assign m_axi.m_axi_bready  = r_bready;
    assign m_axi.m_axi_araddr  = r_addr;
    assign m_axi.m_axi_arvalid = r_arvalid;
    assign m_axi.m_axi_rready  = r_rready;

    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err_cnt;
    assign fail_addr = r_fail_addr;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_reg_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_reg_tester
// Brief    : Self-checking bench with a RAM slave and transaction scoreboard.
// Revision : 1.0
// ============================================================================
module tb_axi_lite_reg_tester;

    localparam int          NREG = 4;
    localparam int          TMO  = 1024;
    localparam logic [31:0] ONES = 32'h01010101;

    logic        tb_ACLK = 1'b0;
    logic        tb_ARESET = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] seed = '0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [31:0] fail_addr;

    axi_lite_reg_tester_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axi_lite_reg_tester #(
        .NUM_REGS(NREG), .DATA_WIDTH(32), .ADDR_WIDTH(32),
        .BASE_ADDR(32'h0), .TIMEOUT(TMO)
    ) dut (
        .ACLK(tb_ACLK), .ARESET(tb_ARESET), .start(start), .mode(mode), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_addr(fail_addr), .m_axi(bus.master)
    );

    always #5 tb_ACLK = ~tb_ACLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Scoreboard of expected bus transactions in issue order
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t exp_q[$];

    task automatic sb_pop(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        txn_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got wr=%0d addr=%0h data=%0h, expected no transaction", wr, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.wr !== wr || e.addr !== a || (wr && (e.data !== d || s !== 4'hF))) begin
                bad++;
                $display("FAIL sb_txn: got wr=%0d addr=%0h data=%0h strb=%0h, expected wr=%0d addr=%0h data=%0h",
                         wr, a, d, s, e.wr, e.addr, e.data);
            end
        end
    endtask

    // Slave knobs and state
    int          aw_lat = 0, w_lat = 0, r_lat = 0, corrupt_idx = -1, bresp_idx = -1;
    bit          aw_stuck = 0;
    bit          have_aw = 0, have_w = 0, b_taken = 0, r_pend = 0, r_taken = 0;
    logic [31:0] aw_a, w_d, r_a;
    logic [3:0]  w_s;
    logic [1:0]  widx, ridx;
    int          aw_wait = 0, w_wait = 0, r_wait = 0;
    int          aw_hs = 0, w_hs = 0, wr_events = 0, ar_hs = 0;
    logic [31:0] mem [NREG];

    task automatic slave_clear();
        have_aw = 0; have_w = 0; b_taken = 0; r_pend = 0; r_taken = 0;
        aw_wait = 0; w_wait = 0; r_wait = 0;
        aw_hs = 0; w_hs = 0; wr_events = 0; ar_hs = 0;
    endtask

    // Handshake monitor: observes the edge, never drives DUT inputs
    always @(posedge tb_ACLK) begin
        if (!tb_ARESET) begin
            if (bus.m_axi_awvalid && bus.m_axi_awready) begin
                have_aw = 1; aw_a = bus.m_axi_awaddr; aw_wait = 0; aw_hs++;
            end
            if (bus.m_axi_wvalid && bus.m_axi_wready) begin
                have_w = 1; w_d = bus.m_axi_wdata; w_s = bus.m_axi_wstrb; w_wait = 0; w_hs++;
            end
            if (bus.m_axi_bvalid && bus.m_axi_bready) b_taken = 1;
            if (bus.m_axi_arvalid && bus.m_axi_arready) begin
                r_pend = 1; r_a = bus.m_axi_araddr; r_wait = 0; ar_hs++;
                sb_pop(1'b0, bus.m_axi_araddr, '0, '0);
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) r_taken = 1;
        end
    end

    // Slave response driver on the falling edge
    always @(negedge tb_ACLK) begin
        if (tb_ARESET) begin
            bus.m_axi_awready = 0; bus.m_axi_wready = 0; bus.m_axi_bvalid = 0; bus.m_axi_bresp = 0;
            bus.m_axi_arready = 0; bus.m_axi_rvalid = 0; bus.m_axi_rdata = 0; bus.m_axi_rresp = 0;
        end else begin
            if (b_taken) begin
                bus.m_axi_bvalid = 0; b_taken = 0;
            end else if (have_aw && have_w && !bus.m_axi_bvalid) begin
                widx = aw_a[3:2];
                mem[widx] = w_d;
                bus.m_axi_bresp  = (int'(widx) == bresp_idx) ? 2'b10 : 2'b00;
                bus.m_axi_bvalid = 1;
                have_aw = 0; have_w = 0; wr_events++;
                sb_pop(1'b1, aw_a, w_d, w_s);
            end
            if (bus.m_axi_awvalid && !have_aw && !aw_stuck && aw_wait >= aw_lat) bus.m_axi_awready = 1;
            else begin
                bus.m_axi_awready = 0;
                if (bus.m_axi_awvalid && !have_aw) aw_wait++;
            end
            if (bus.m_axi_wvalid && !have_w && w_wait >= w_lat) bus.m_axi_wready = 1;
            else begin
                bus.m_axi_wready = 0;
                if (bus.m_axi_wvalid && !have_w) w_wait++;
            end
            bus.m_axi_arready = bus.m_axi_arvalid && !r_pend;
            if (r_taken) begin
                bus.m_axi_rvalid = 0; r_taken = 0; r_pend = 0;
            end else if (r_pend && !bus.m_axi_rvalid) begin
                if (r_wait >= r_lat) begin
                    ridx = r_a[3:2];
                    bus.m_axi_rdata  = mem[ridx] ^ ((int'(ridx) == corrupt_idx) ? 32'h1 : 32'h0);
                    bus.m_axi_rresp  = 2'b00;
                    bus.m_axi_rvalid = 1;
                end else begin
                    r_wait++;
                end
            end
        end
    end

    typedef struct {
        logic        md;
        logic [31:0] sd;
        int          awl, wl, rl, cor, bre;
        logic        ep;
        logic [15:0] ee;
        logic [31:0] ef;
    } tv_t;
    tv_t tv [7];

    task automatic setup(input tv_t v);
        txn_t t;
        aw_lat = v.awl; w_lat = v.wl; r_lat = v.rl;
        corrupt_idx = v.cor; bresp_idx = v.bre; aw_stuck = 0;
        slave_clear();
        exp_q.delete();
        for (int i = 0; i < NREG; i++) begin
            t.wr = 1; t.addr = 32'(i * 4); t.data = v.sd + 32'(i) * ONES;
            exp_q.push_back(t);
            if (!v.md) begin
                t.wr = 0; t.data = '0;
                exp_q.push_back(t);
            end
        end
        if (v.md) begin
            for (int i = 0; i < NREG; i++) begin
                t.wr = 0; t.addr = 32'(i * 4); t.data = '0;
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic run_pass(input tv_t v, input int n);
        int cyc;
        setup(v);
        @(negedge tb_ACLK);
        mode = v.md; seed = v.sd; start = 1;
        @(negedge tb_ACLK);
        start = 0;
        check($sformatf("v%0d_busy_after_start", n), busy, 1);
        // A start while busy must be ignored; altered mode/seed would show on the bus.
        mode = ~v.md; seed = ~v.sd; start = 1;
        @(negedge tb_ACLK);
        start = 0; mode = v.md; seed = v.sd;
        cyc = 0;
        while (!done && cyc < 2000) begin
            @(negedge tb_ACLK);
            cyc++;
        end
        check($sformatf("v%0d_done", n), done, 1);
        check($sformatf("v%0d_busy_end", n), busy, 0);
        check($sformatf("v%0d_pass", n), pass, v.ep);
        check($sformatf("v%0d_err_count", n), err_count, v.ee);
        check($sformatf("v%0d_fail_addr", n), fail_addr, v.ef);
        check($sformatf("v%0d_sb_left", n), exp_q.size(), 0);
        check($sformatf("v%0d_aw_count", n), aw_hs, NREG);
        check($sformatf("v%0d_w_count", n), w_hs, NREG);
        check($sformatf("v%0d_ar_count", n), ar_hs, NREG);
        @(negedge tb_ACLK);
        check($sformatf("v%0d_done_pulse", n), done, 0);
        check($sformatf("v%0d_pass_held", n), pass, v.ep);
    endtask

    initial begin
        tv_t v;
        int  cyc;
        tv[0] = '{1'b0, 32'h0101FFFF, 0, 0, 0, -1, -1, 1'b1, 16'd0, 32'h0};
        tv[1] = '{1'b1, 32'h0101FFFF, 0, 0, 0, -1, -1, 1'b1, 16'd0, 32'h0};
        tv[2] = '{1'b0, 32'h0101FFFF, 0, 0, 0,  2, -1, 1'b0, 16'd1, 32'h8};
        tv[3] = '{1'b0, 32'h12345678, 3, 0, 1, -1, -1, 1'b1, 16'd0, 32'h0};
        tv[4] = '{1'b1, 32'hDEADBEEF, 1, 1, 2, -1, -1, 1'b1, 16'd0, 32'h0};
        tv[5] = '{1'b1, 32'hA5A5A5A5, 0, 2, 0,  3,  1, 1'b0, 16'd2, 32'h4};
        tv[6] = '{1'b0, 32'hFFFFFFFF, 0, 4, 3,  0, -1, 1'b0, 16'd1, 32'h0};

        repeat (3) @(negedge tb_ACLK);
        check("reset_ctrl", {busy, done, pass, bus.m_axi_awvalid, bus.m_axi_wvalid,
                             bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready}, 0);
        check("reset_err", err_count, 0);
        check("reset_fail_addr", fail_addr, 0);
        tb_ARESET = 0;
        repeat (2) @(negedge tb_ACLK);

        for (int i = 0; i < 7; i++) run_pass(tv[i], i);

        // Write address never accepted: the pass must abort on the timeout.
        v = tv[0];
        setup(v);
        exp_q.delete();
        aw_stuck = 1;
        @(negedge tb_ACLK);
        start = 1;
        @(negedge tb_ACLK);
        start = 0;
        cyc = 1;
        while (!done && cyc < TMO + 100) begin
            @(negedge tb_ACLK);
            cyc++;
        end
        check("tmo_done", done, 1);
        check("tmo_latency", (cyc >= TMO && cyc <= TMO + 4), 1);
        check("tmo_err_count", err_count, 1);
        check("tmo_fail_addr", fail_addr, 0);
        check("tmo_pass", pass, 0);
        check("tmo_no_writes", wr_events, 0);
        aw_stuck = 0;
        repeat (2) @(negedge tb_ACLK);

        // Reset while a read is outstanding, after one error has been logged.
        v = tv[0]; v.rl = 5; v.cor = 1;
        setup(v);
        @(negedge tb_ACLK);
        mode = 0; seed = v.sd; start = 1;
        @(negedge tb_ACLK);
        start = 0;
        cyc = 0;
        while (!(bus.m_axi_rready && err_count == 16'd1) && cyc < 500) begin
            @(negedge tb_ACLK);
            cyc++;
        end
        check("rst_reached_rdata", (bus.m_axi_rready && err_count == 16'd1), 1);
        check("rst_pre_fail_addr", fail_addr, 32'h4);
        #2 tb_ARESET = 1;
        #1;
        check("rst_mid_ctrl", {busy, done, pass, bus.m_axi_awvalid, bus.m_axi_wvalid,
                               bus.m_axi_bready, bus.m_axi_arvalid, bus.m_axi_rready}, 0);
        check("rst_mid_err", err_count, 0);
        check("rst_mid_fail_addr", fail_addr, 0);
        @(negedge tb_ACLK);
        tb_ARESET = 0;
        slave_clear();
        exp_q.delete();
        run_pass(tv[0], 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
